// File: rtl/flex_pts_serializer_if.sv
// ---------------------------------------------------------------------------
// flex_pts_serializer_if
// Bundles the producer handshake, the bit-time strobe/abort controls and the
// serial-line status signals of flex_pts_serializer.
//   master : drives clear, shift_enable, load_valid, parallel_in;
//            observes load_ready, serial_out, busy, frame_done
//   slave  : the serializer side (mirror of master)
// Parameter NUM_BITS must match the serializer's frame width.
// ---------------------------------------------------------------------------
interface flex_pts_serializer_if #(
  parameter int NUM_BITS = 8
);
  logic                clear;
  logic                shift_enable;
  logic                load_valid;
  logic                load_ready;
  logic [NUM_BITS-1:0] parallel_in;
  logic                serial_out;
  logic                busy;
  logic                frame_done;

  modport master (
    output clear,
    output shift_enable,
    output load_valid,
    output parallel_in,
    input  load_ready,
    input  serial_out,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  clear,
    input  shift_enable,
    input  load_valid,
    input  parallel_in,
    output load_ready,
    output serial_out,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/flex_pts_serializer.sv
// ---------------------------------------------------------------------------
// flex_pts_serializer
// Parallel-to-serial converter with a one-entry hold register so the next
// frame can be queued while the current one shifts out, giving gapless
// back-to-back frames. Bit timing comes from the external shift_enable strobe.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   n_rst : asynchronous active-low reset
//   bus   : flex_pts_serializer_if.slave
//           clear        - synchronous abort of frame and hold register
//           shift_enable - one bit per high cycle while shifting
//           load_valid / load_ready / parallel_in - word handshake
//           serial_out   - registered serial line
//           busy         - frame in progress or word queued
//           frame_done   - one-cycle pulse per completed frame
// Parameters:
//   NUM_BITS   : frame width (>= 2)
//   SHIFT_MSB  : 1 = MSB first, 0 = LSB first
//   IDLE_LEVEL : idle line level and fill bit
// ---------------------------------------------------------------------------
module flex_pts_serializer #(
  parameter int NUM_BITS   = 8,
  parameter bit SHIFT_MSB  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input logic                  clk,
  input logic                  n_rst,
  flex_pts_serializer_if.slave bus
);

  localparam int                  CNT_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0]    ZERO_CNT  = CNT_W'(0);
  localparam logic [CNT_W-1:0]    ONE_CNT   = CNT_W'(1);
  localparam logic [NUM_BITS-1:0] FILL_WORD = {NUM_BITS{IDLE_LEVEL}};
  localparam int                  OUT_IDX   = SHIFT_MSB ? (NUM_BITS - 1) : 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Moves the word one position toward the output end, filling the vacated
  // end with the idle level.
  function automatic logic [NUM_BITS-1:0] shift_step(input logic [NUM_BITS-1:0] word);
    logic [NUM_BITS-1:0] res;
    if (SHIFT_MSB) begin
      res = {word[NUM_BITS-2:0], IDLE_LEVEL};
    end else begin
      res = {IDLE_LEVEL, word[NUM_BITS-1:1]};
    end
    return res;
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [NUM_BITS-1:0] hold_data_r;
  logic [NUM_BITS-1:0] hold_data_s;
  logic                hold_full_r;
  logic                hold_full_s;
  logic [NUM_BITS-1:0] shift_r;
  logic [NUM_BITS-1:0] shift_s;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [CNT_W-1:0]    bit_cnt_s;
  logic                frame_done_s;
  logic                busy_s;
  logic                accept_s;

  logic                serial_out_r;
  logic                load_ready_r;
  logic                busy_r;
  logic                frame_done_r;

  // load_ready_r is the registered image of !hold_full, so acceptance never
  // depends combinationally on load_valid reaching load_ready.
  assign accept_s = bus.load_valid & load_ready_r & ~bus.clear;

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath next values; clear overrides everything.
  always_comb begin
    state_s      = state_r;
    hold_data_s  = hold_data_r;
    hold_full_s  = hold_full_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    frame_done_s = 1'b0;

    if (bus.clear) begin
      state_s     = ST_IDLE;
      hold_full_s = 1'b0;
      shift_s     = FILL_WORD;
      bit_cnt_s   = ZERO_CNT;
    end else begin
      // Acceptance only happens with the hold register empty, so it can
      // never collide with the hold register being drained below.
      if (accept_s) begin
        hold_data_s = bus.parallel_in;
        hold_full_s = 1'b1;
      end else begin
        hold_data_s = hold_data_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (hold_full_r) begin
            shift_s     = hold_data_r;
            bit_cnt_s   = ZERO_CNT;
            hold_full_s = 1'b0;
            state_s     = ST_SHIFT;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bus.shift_enable) begin
            if (bit_cnt_r == LAST_CNT) begin
              frame_done_s = 1'b1;
              bit_cnt_s    = ZERO_CNT;
              if (hold_full_r) begin
                // Queued word follows immediately: no idle bit between frames.
                shift_s     = hold_data_r;
                hold_full_s = 1'b0;
                state_s     = ST_SHIFT;
              end else begin
                shift_s = FILL_WORD;
                state_s = ST_IDLE;
              end
            end else begin
              shift_s   = shift_step(shift_r);
              bit_cnt_s = bit_cnt_r + ONE_CNT;
            end
          end else begin
            state_s = ST_SHIFT;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          hold_full_s = 1'b0;
          shift_s     = FILL_WORD;
          bit_cnt_s   = ZERO_CNT;
        end
      endcase
    end

    busy_s = (state_s == ST_SHIFT) | hold_full_s;
  end

  // Datapath registers: hold register, shifter and bit counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_data_r <= {NUM_BITS{1'b0}};
      hold_full_r <= 1'b0;
      shift_r     <= FILL_WORD;
      bit_cnt_r   <= ZERO_CNT;
    end else begin
      hold_data_r <= hold_data_s;
      hold_full_r <= hold_full_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
    end
  end

  // Output registers. serial_out follows the shifter output bit one clock
  // later, except that clear drives the line idle on the aborting edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      serial_out_r <= IDLE_LEVEL;
      load_ready_r <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      if (bus.clear) begin
        serial_out_r <= IDLE_LEVEL;
      end else begin
        serial_out_r <= shift_r[OUT_IDX];
      end
      load_ready_r <= ~hold_full_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
    end
  end

  assign bus.serial_out = serial_out_r;
  assign bus.load_ready = load_ready_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_flex_pts_serializer.sv
// ---------------------------------------------------------------------------
// tb_flex_pts_serializer
// Directed self-checking bench for flex_pts_serializer. Two instances share
// clk/n_rst: dut_m (MSB first) and dut_l (LSB first), both 8-bit, idle = 1.
// ---------------------------------------------------------------------------
module tb_flex_pts_serializer;

  logic clk;
  logic n_rst;
  int   n_cmp;
  int   n_fail;
  int   fd_m;
  int   fd_l;

  flex_pts_serializer_if #(.NUM_BITS(8)) bus_m ();
  flex_pts_serializer_if #(.NUM_BITS(8)) bus_l ();

  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_m)
  );

  flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_l)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses independently of the test flow.
  always @(posedge clk) begin
    if (bus_m.frame_done === 1'b1) fd_m <= fd_m + 1;
    if (bus_l.frame_done === 1'b1) fd_l <= fd_l + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Three quiet cycles, sample both lines, then one strobe cycle.
  task automatic strobe(output logic so_m, output logic so_l);
    repeat (3) tick();
    so_m = bus_m.serial_out;
    so_l = bus_l.serial_out;
    bus_m.shift_enable = 1'b1;
    bus_l.shift_enable = 1'b1;
    tick();
    bus_m.shift_enable = 1'b0;
    bus_l.shift_enable = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    n_cmp++; if (bus_m.serial_out !== 1'b1) begin n_fail++; $display("FAIL rst_serial_out: got %b want 1", bus_m.serial_out); end
    n_cmp++; if (bus_m.load_ready !== 1'b1) begin n_fail++; $display("FAIL rst_load_ready: got %b want 1", bus_m.load_ready); end
    n_cmp++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_m.busy); end
    n_cmp++; if (bus_m.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", bus_m.frame_done); end
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    tick();
  endtask

  task automatic test_idle_strobe;
    for (int i = 0; i < 6; i++) begin
      bus_m.shift_enable = i[0];
      tick();
      n_cmp++; if (bus_m.serial_out !== 1'b1 || bus_m.busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_strobe[%0d]: got so=%b busy=%b want so=1 busy=0", i, bus_m.serial_out, bus_m.busy);
      end
    end
    bus_m.shift_enable = 1'b0;
    n_cmp++; if (bus_m.load_ready !== 1'b1) begin n_fail++; $display("FAIL idle_load_ready: got %b want 1", bus_m.load_ready); end
    n_cmp++; if (fd_m !== 0) begin n_fail++; $display("FAIL idle_frame_done: got %0d pulses want 0", fd_m); end
  endtask

  task automatic test_single_frame;
    logic [7:0] word;
    logic       so_m, so_l;
    int         fd0;
    word = 8'hA5;
    fd0  = fd_m;
    bus_m.parallel_in = word;
    bus_m.load_valid  = 1'b1;
    tick();
    bus_m.load_valid = 1'b0;
    n_cmp++; if (bus_m.load_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_after_accept: got %b want 0", bus_m.load_ready); end
    n_cmp++; if (bus_m.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus_m.busy); end
    tick();
    n_cmp++; if (bus_m.load_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after_move: got %b want 1", bus_m.load_ready); end
    for (int i = 0; i < 8; i++) begin
      strobe(so_m, so_l);
      n_cmp++; if (so_m !== word[7-i]) begin n_fail++; $display("FAIL single_bit[%0d]: got %b want %b", i, so_m, word[7-i]); end
    end
    n_cmp++; if (bus_m.frame_done !== 1'b1) begin n_fail++; $display("FAIL single_frame_done_pulse: got %b want 1", bus_m.frame_done); end
    tick();
    n_cmp++; if (bus_m.frame_done !== 1'b0) begin n_fail++; $display("FAIL single_frame_done_width: got %b want 0", bus_m.frame_done); end
    n_cmp++; if (bus_m.serial_out !== 1'b1) begin n_fail++; $display("FAIL single_idle_line: got %b want 1", bus_m.serial_out); end
    n_cmp++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", bus_m.busy); end
    n_cmp++; if (fd_m - fd0 !== 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", fd_m - fd0); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] stream;
    logic        so_m, so_l;
    int          fd0;
    stream = 16'hA53C;
    fd0    = fd_m;
    bus_m.parallel_in = 8'hA5;
    bus_m.load_valid  = 1'b1;
    tick();
    n_cmp++; if (bus_m.load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_a5_held: got %b want 0", bus_m.load_ready); end
    bus_m.parallel_in = 8'h3C;
    tick();
    n_cmp++; if (bus_m.load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_a5_moved: got %b want 1", bus_m.load_ready); end
    tick();
    bus_m.load_valid = 1'b0;
    n_cmp++; if (bus_m.load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_3c_held: got %b want 0", bus_m.load_ready); end
    for (int i = 0; i < 16; i++) begin
      strobe(so_m, so_l);
      n_cmp++; if (so_m !== stream[15-i]) begin n_fail++; $display("FAIL b2b_bit[%0d]: got %b want %b", i, so_m, stream[15-i]); end
      if (i < 7) begin
        n_cmp++; if (bus_m.load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low[%0d]: got %b want 0", i, bus_m.load_ready); end
      end else if (i == 7) begin
        n_cmp++; if (bus_m.load_ready !== 1'b1 || bus_m.frame_done !== 1'b1) begin
          n_fail++; $display("FAIL b2b_boundary: got ready=%b done=%b want ready=1 done=1", bus_m.load_ready, bus_m.frame_done);
        end
      end
    end
    tick();
    n_cmp++; if (fd_m - fd0 !== 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d want 2", fd_m - fd0); end
    n_cmp++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", bus_m.busy); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] word;
    logic       so_m, so_l;
    int         fd0;
    word = 8'h0F;
    fd0  = fd_l;
    bus_l.parallel_in = word;
    bus_l.load_valid  = 1'b1;
    tick();
    bus_l.load_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      strobe(so_m, so_l);
      n_cmp++; if (so_l !== word[i]) begin n_fail++; $display("FAIL lsb_bit[%0d]: got %b want %b", i, so_l, word[i]); end
    end
    tick();
    n_cmp++; if (fd_l - fd0 !== 1) begin n_fail++; $display("FAIL lsb_pulse_count: got %0d want 1", fd_l - fd0); end
    n_cmp++; if (bus_l.serial_out !== 1'b1) begin n_fail++; $display("FAIL lsb_idle_line: got %b want 1", bus_l.serial_out); end
  endtask

  task automatic test_clear;
    logic so_m, so_l;
    int   fd0;
    fd0 = fd_m;
    bus_m.parallel_in = 8'h00;
    bus_m.load_valid  = 1'b1;
    tick();
    bus_m.parallel_in = 8'hFF;
    tick();
    tick();
    bus_m.load_valid = 1'b0;
    n_cmp++; if (bus_m.load_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ff_queued: got ready=%b want 0", bus_m.load_ready); end
    for (int i = 0; i < 3; i++) begin
      strobe(so_m, so_l);
      n_cmp++; if (so_m !== 1'b0) begin n_fail++; $display("FAIL clr_bit[%0d]: got %b want 0", i, so_m); end
    end
    n_cmp++; if (bus_m.busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_before: got %b want 1", bus_m.busy); end
    bus_m.clear = 1'b1;
    tick();
    bus_m.clear = 1'b0;
    n_cmp++; if (bus_m.serial_out !== 1'b1) begin n_fail++; $display("FAIL clr_serial_out: got %b want 1", bus_m.serial_out); end
    n_cmp++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", bus_m.busy); end
    n_cmp++; if (bus_m.load_ready !== 1'b1) begin n_fail++; $display("FAIL clr_load_ready: got %b want 1", bus_m.load_ready); end
    n_cmp++; if (bus_m.frame_done !== 1'b0) begin n_fail++; $display("FAIL clr_frame_done: got %b want 0", bus_m.frame_done); end
    for (int i = 0; i < 10; i++) begin
      strobe(so_m, so_l);
      n_cmp++; if (so_m !== 1'b1 || bus_m.busy !== 1'b0) begin
        n_fail++; $display("FAIL clr_ff_sent[%0d]: got so=%b busy=%b want so=1 busy=0", i, so_m, bus_m.busy);
      end
    end
    n_cmp++; if (fd_m - fd0 !== 0) begin n_fail++; $display("FAIL clr_pulse_count: got %0d want 0", fd_m - fd0); end
  endtask

  task automatic test_clear_drops_load;
    bus_m.parallel_in = 8'h55;
    bus_m.load_valid  = 1'b1;
    bus_m.clear       = 1'b1;
    tick();
    bus_m.load_valid = 1'b0;
    bus_m.clear      = 1'b0;
    n_cmp++; if (bus_m.load_ready !== 1'b1) begin n_fail++; $display("FAIL clrload_ready: got %b want 1", bus_m.load_ready); end
    tick();
    n_cmp++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL clrload_busy: got %b want 0", bus_m.busy); end
  endtask

  task automatic test_async_reset;
    logic [7:0] word;
    logic       so_m, so_l;
    int         fd0;
    fd0 = fd_m;
    bus_m.parallel_in = 8'h00;
    bus_m.load_valid  = 1'b1;
    tick();
    bus_m.load_valid = 1'b0;
    tick();
    strobe(so_m, so_l);
    strobe(so_m, so_l);
    n_cmp++; if (bus_m.busy !== 1'b1 || bus_m.serial_out !== 1'b0) begin
      n_fail++; $display("FAIL arst_midframe: got busy=%b so=%b want busy=1 so=0", bus_m.busy, bus_m.serial_out);
    end
    #2 n_rst = 1'b0;
    #1;
    n_cmp++; if (bus_m.serial_out !== 1'b1) begin n_fail++; $display("FAIL arst_serial_out: got %b want 1", bus_m.serial_out); end
    n_cmp++; if (bus_m.load_ready !== 1'b1) begin n_fail++; $display("FAIL arst_load_ready: got %b want 1", bus_m.load_ready); end
    n_cmp++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", bus_m.busy); end
    n_cmp++; if (bus_m.frame_done !== 1'b0) begin n_fail++; $display("FAIL arst_frame_done: got %b want 0", bus_m.frame_done); end
    #2 n_rst = 1'b1;
    word = 8'h81;
    bus_m.parallel_in = word;
    bus_m.load_valid  = 1'b1;
    tick();
    bus_m.load_valid = 1'b0;
    n_cmp++; if (bus_m.load_ready !== 1'b0) begin n_fail++; $display("FAIL arst_first_load: got ready=%b want 0", bus_m.load_ready); end
    tick();
    for (int i = 0; i < 8; i++) begin
      strobe(so_m, so_l);
      n_cmp++; if (so_m !== word[7-i]) begin n_fail++; $display("FAIL arst_bit[%0d]: got %b want %b", i, so_m, word[7-i]); end
    end
    tick();
    n_cmp++; if (fd_m - fd0 !== 1) begin n_fail++; $display("FAIL arst_pulse_count: got %0d want 1", fd_m - fd0); end
  endtask

  initial begin
    clk    = 1'b0;
    n_rst  = 1'b1;
    n_cmp  = 0;
    n_fail = 0;
    fd_m   = 0;
    fd_l   = 0;
    bus_m.clear = 1'b0; bus_m.shift_enable = 1'b0; bus_m.load_valid = 1'b0; bus_m.parallel_in = 8'h00;
    bus_l.clear = 1'b0; bus_l.shift_enable = 1'b0; bus_l.load_valid = 1'b0; bus_l.parallel_in = 8'h00;

    test_reset();
    test_idle_strobe();
    test_single_frame();
    test_back_to_back();
    test_lsb_first();
    test_clear();
    test_clear_drops_load();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flex_pts_serializer.md
FLEX_PTS_SERIALIZER -- requirements
Module: flex_pts_serializer

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 8, frame width in bits (legal range >= 2).
REQ-002 The block SHALL have parameter SHIFT_MSB, default 1: 1 = MSB first, 0 = LSB first.
REQ-003 The block SHALL have parameter IDLE_LEVEL, default 1: line level when idle, and fill bit shifted in.
REQ-004 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-005 The block SHALL have port n_rst, input, 1, reset: asynchronous, active-low.
REQ-006 The block SHALL have port clear, input, 1, synchronous abort of the current frame and the hold register.
REQ-007 The block SHALL have port shift_enable, input, 1, bit-time strobe; each high cycle advances one bit.
REQ-008 The block SHALL have port load_valid, input, 1, producer offers parallel_in.
REQ-009 The block SHALL have port load_ready, output, 1, hold register empty; a word is accepted when load_valid && load_ready.
REQ-010 The block SHALL have port parallel_in, input, NUM_BITS, frame data.
REQ-011 The block SHALL have port serial_out, output, 1, registered serial line.
REQ-012 The block SHALL have port busy, output, 1, high when state is SHIFT or the hold register is full.
REQ-013 The block SHALL have port frame_done, output, 1, one-cycle pulse per completed frame.

Function
REQ-014 The datapath SHALL consist of a one-entry hold register (hold_data, hold_full), a NUM_BITS shift register, and a bit counter of width clog2(NUM_BITS).
REQ-015 load_ready SHALL equal !hold_full, driven from a register only, with no combinational path from load_valid.
REQ-016 On an accepted word, hold_data SHALL capture parallel_in and hold_full SHALL set at the same edge.
REQ-017 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-018 In IDLE with hold_full = 1: the shift register SHALL load hold_data, bit_cnt = 0, hold_full clears, and the FSM moves to SHIFT.
REQ-019 With REQ-018, the first bit SHALL appear on serial_out 2 clocks after the accepting edge.
REQ-020 serial_out SHALL equal shift-register bit NUM_BITS-1 when SHIFT_MSB = 1, else bit 0.
REQ-021 In SHIFT, shift_enable with bit_cnt < NUM_BITS-1 SHALL shift one position toward the output end, insert IDLE_LEVEL at the opposite end, and increment bit_cnt.
REQ-022 In SHIFT, shift_enable with bit_cnt = NUM_BITS-1 SHALL end the frame: frame_done pulses high for the next cycle.
REQ-023 At frame end with hold_full = 1: the shift register SHALL reload from hold_data, bit_cnt = 0, hold_full clears, and the FSM stays in SHIFT, giving a gapless next frame.
REQ-024 At frame end with hold_full = 0: the shift register SHALL fill with IDLE_LEVEL and the FSM moves to IDLE.
REQ-025 shift_enable in IDLE SHALL be ignored.
REQ-026 shift_enable low in SHIFT SHALL hold all state, with no timeout.
REQ-027 clear SHALL take priority over load acceptance and shifting.
REQ-028 On clear, the next edge SHALL give: state IDLE, hold_full = 0, shift register all IDLE_LEVEL, bit_cnt = 0, and no frame_done pulse.
REQ-029 A load_valid presented in the same cycle as clear SHALL be dropped.
REQ-030 A word accepted in the same cycle as a frame end SHALL be impossible, because load_ready is low whenever hold_full is high.
REQ-031 bit_cnt SHALL never exceed NUM_BITS-1; it wraps to 0 only on a frame boundary.

Reset
REQ-032 While n_rst = 0, independent of clk: state IDLE, bit_cnt = 0, hold_full = 0, shift register all IDLE_LEVEL.
REQ-033 Outputs during reset SHALL be: serial_out = IDLE_LEVEL, load_ready = 1, busy = 0, frame_done = 0.
REQ-034 Reset asserted mid-frame SHALL discard all data and SHALL produce no frame_done.
REQ-035 After deassertion, the block SHALL accept a load on the first clock edge.

Verification (NUM_BITS = 8, SHIFT_MSB = 1, IDLE_LEVEL = 1 unless stated)
REQ-036 Reset with no stimulus -> serial_out = 1, load_ready = 1, busy = 0, frame_done = 0; shift_enable toggling leaves all outputs unchanged.
REQ-037 Load 8'hA5, shift_enable every 4th cycle -> serial_out 1,0,1,0,0,1,0,1; one frame_done pulse the cycle after the 8th strobe; serial_out then 1 and busy = 0.
REQ-038 Load 8'hA5, then 8'h3C offered continuously -> load_ready low until the 3C word is accepted and again until it moves into the shifter; 16 contiguous bits A5 then 3C; exactly 2 frame_done pulses.
REQ-039 SHIFT_MSB = 0, load 8'h0F -> serial_out 1,1,1,1,0,0,0,0.
REQ-040 clear after the 3rd strobe of 8'h00, with 8'hFF held -> next cycle serial_out = 1, busy = 0, load_ready = 1; no frame_done; the FF word is never transmitted.
REQ-041 n_rst pulsed low mid-frame between clock edges -> outputs take reset values immediately; after release, a fresh 8'h81 transmits correctly.
